windowed_integrator: RTL and testbench

//  Streaming moving-window integrator for ADC samples: keeps a running sum of the last WIN accepted samples
//  in a circular buffer, then scales the sum by a programmable sample interval (rectangle-rule integral).

---
 rtl/windowed_integrator.sv | 136 +++++++++++++
 tb/tb_windowed_integrator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/windowed_integrator.sv
// Moving-window integrator: running sum of the last WIN accepted ADC samples in a
// circular buffer, scaled by a programmable sample interval (rectangle-rule integral).
module windowed_integrator #(
  parameter  int DATA_W  = 16,
  parameter  int DEPTH   = 32,
  parameter  int SCALE_W = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int SUM_W   = DATA_W + PTR_W + 1,
  localparam int OUT_W   = SUM_W + SCALE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  din,
  input  logic               cfg_load,
  input  logic [PTR_W:0]     cfg_window,
  input  logic [SCALE_W-1:0] cfg_interval,
  output logic [OUT_W-1:0]   integral,
  output logic               out_valid,
  output logic               win_full,
  output logic [PTR_W:0]     fill_count
);

  logic [DATA_W-1:0]  r_buf [DEPTH];
  logic [PTR_W:0]     r_win;
  logic [SCALE_W-1:0] r_interval;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_fill;
  logic [SUM_W-1:0]   r_sum;
  logic               r_s1_full;
  logic               r_s2_valid;
  logic [OUT_W-1:0]   r_product;
  logic [OUT_W-1:0]   r_integral;
  logic               r_out_valid;
  logic               r_win_full;

  logic               w_accept;
  logic               w_full_now;
  logic [PTR_W:0]     w_win_cfg;
  logic [PTR_W:0]     w_next_fill;
  logic [SUM_W-1:0]   w_next_sum;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [DATA_W-1:0]  w_oldest;

  assign w_accept   = sample_valid & ~cfg_load;
  assign w_full_now = (r_fill == r_win);
  assign w_oldest   = r_buf[r_wr_ptr];

  // Clamp the requested window into 1..DEPTH
  always_comb begin
    w_win_cfg = cfg_window;
    if (cfg_window == {(PTR_W+1){1'b0}}) begin
      w_win_cfg = (PTR_W+1)'(1);
    end else if (cfg_window > (PTR_W+1)'(DEPTH)) begin
      w_win_cfg = (PTR_W+1)'(DEPTH);
    end else begin
      w_win_cfg = cfg_window;
    end
  end

  // Next window state for an accepted sample; a full window evicts the slot about to be overwritten
  always_comb begin
    w_next_fill = r_fill;
    w_next_sum  = r_sum;
    w_next_ptr  = r_wr_ptr;
    if (w_full_now) begin
      w_next_fill = r_fill;
      w_next_sum  = r_sum + SUM_W'(din) - SUM_W'(w_oldest);
    end else begin
      w_next_fill = r_fill + (PTR_W+1)'(1);
      w_next_sum  = r_sum + SUM_W'(din);
    end
    if ({1'b0, r_wr_ptr} == (r_win - (PTR_W+1)'(1))) begin
      w_next_ptr = {PTR_W{1'b0}};
    end else begin
      w_next_ptr = r_wr_ptr + PTR_W'(1);
    end
  end

  // Sample storage; contents are never cleared because fill_count gates their use
  always_ff @(posedge clk) begin
    if (w_accept && !reset) begin
      r_buf[r_wr_ptr] <= din;
    end
  end

  // Window state, configuration and the two-stage scale pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win       <= (PTR_W+1)'(DEPTH);
      r_interval  <= SCALE_W'(1);
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_fill      <= {(PTR_W+1){1'b0}};
      r_sum       <= {SUM_W{1'b0}};
      r_s1_full   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_product   <= {OUT_W{1'b0}};
      r_integral  <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_win_full  <= 1'b0;
    end else if (cfg_load) begin
      // Restart: squash everything in flight, but integral keeps its last value
      r_win       <= w_win_cfg;
      r_interval  <= cfg_interval;
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_fill      <= {(PTR_W+1){1'b0}};
      r_sum       <= {SUM_W{1'b0}};
      r_s1_full   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_win_full  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= w_next_ptr;
        r_fill     <= w_next_fill;
        r_sum      <= w_next_sum;
        r_win_full <= (w_next_fill == r_win);
        r_s1_full  <= (w_next_fill == r_win);
      end else begin
        r_s1_full  <= 1'b0;
      end
      r_s2_valid  <= r_s1_full;
      r_product   <= OUT_W'(r_sum) * OUT_W'(r_interval);
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_integral <= r_product;
      end
    end
  end

  assign integral   = r_integral;
  assign out_valid  = r_out_valid;
  assign win_full   = r_win_full;
  assign fill_count = r_fill;

endmodule

// File: tb/tb_windowed_integrator.sv
// Directed bench for windowed_integrator: expected integrals are queued at stimulus time
// and a negedge monitor pops one per out_valid pulse.
module tb_windowed_integrator;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] din;
  logic        cfg_load;
  logic [5:0]  cfg_window;
  logic [7:0]  cfg_interval;
  logic [29:0] integral;
  logic        out_valid;
  logic        win_full;
  logic [5:0]  fill_count;

  int     n_cmp;
  int     n_err;
  longint exp_q[$];

  windowed_integrator dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .din(din),
    .cfg_load(cfg_load), .cfg_window(cfg_window), .cfg_interval(cfg_interval),
    .integral(integral), .out_valid(out_valid), .win_full(win_full),
    .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] d);
    sample_valid = 1'b1;
    din          = d;
    cyc();
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic cfg(input logic [5:0] w, input logic [7:0] iv);
    idle(3);
    cfg_load     = 1'b1;
    cfg_window   = w;
    cfg_interval = iv;
    cyc();
    cfg_load     = 1'b0;
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got integral %0d expected no out_valid", integral);
      end else begin
        chk("scoreboard_integral", longint'(integral), exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; sample_valid = 1'b0; din = 16'd0;
    cfg_load = 1'b0; cfg_window = 6'd0; cfg_interval = 8'd0;
    repeat (3) cyc();
    chk("rst_integral", longint'(integral), 64'd0);
    chk("rst_out_valid", longint'(out_valid), 64'd0);
    chk("rst_win_full", longint'(win_full), 64'd0);
    chk("rst_fill", longint'(fill_count), 64'd0);
    reset = 1'b0;
    cyc();

    // Default window 32, interval 1, with explicit latency checks
    for (int i = 0; i < 32; i++) begin
      if (i == 31) exp_q.push_back(64'd3200);
      sample(16'd100);
    end
    chk("t1_fill", longint'(fill_count), 64'd32);
    chk("t1_win_full", longint'(win_full), 64'd1);
    chk("t1_ov_n0", longint'(out_valid), 64'd0);
    idle(1);
    chk("t1_ov_n1", longint'(out_valid), 64'd0);
    cyc();
    chk("t1_ov_n2", longint'(out_valid), 64'd1);
    chk("t1_integral", longint'(integral), 64'd3200);
    cyc();
    chk("t1_ov_pulse", longint'(out_valid), 64'd0);

    // Window 4, interval 10, back-to-back 1..6
    cfg(6'd4, 8'd10);
    chk("t2_fill_clr", longint'(fill_count), 64'd0);
    chk("t2_wf_clr", longint'(win_full), 64'd0);
    exp_q.push_back(64'd100);
    exp_q.push_back(64'd140);
    exp_q.push_back(64'd180);
    for (int i = 1; i <= 6; i++) sample(16'(i));
    idle(3);
    chk("t2_win_full", longint'(win_full), 64'd1);
    chk("t2_fill", longint'(fill_count), 64'd4);
    chk("t2_integral", longint'(integral), 64'd180);

    // Reconfigure with sample_valid high: that sample is dropped
    sample_valid = 1'b1; din = 16'd999;
    cfg_load = 1'b1; cfg_window = 6'd2; cfg_interval = 8'd3;
    cyc();
    cfg_load = 1'b0;
    sample_valid = 1'b0;
    chk("t3_fill", longint'(fill_count), 64'd0);
    chk("t3_win_full", longint'(win_full), 64'd0);
    idle(3);
    chk("t3_integral_hold", longint'(integral), 64'd180);
    exp_q.push_back(64'd45);
    exp_q.push_back(64'd51);
    sample(16'd7); sample(16'd8); sample(16'd9);

    // Window 0 clamps to 1: each sample stands alone
    cfg(6'd0, 8'd7);
    exp_q.push_back(64'd35);
    exp_q.push_back(64'd63);
    exp_q.push_back(64'd458745);
    sample(16'd5); sample(16'd9); sample(16'hFFFF);
    chk("t4_fill_w1", longint'(fill_count), 64'd1);

    // Window 40 clamps to 32; the 33rd sample evicts the first
    cfg(6'd40, 8'd1);
    exp_q.push_back(64'd528);
    exp_q.push_back(64'd1527);
    for (int i = 1; i <= 32; i++) sample(16'(i));
    sample(16'd1000);
    idle(3);
    chk("t4_fill_w32", longint'(fill_count), 64'd32);

    // Largest possible integral, no wrap
    cfg(6'd32, 8'd255);
    for (int i = 0; i < 34; i++) begin
      if (i >= 31) exp_q.push_back(64'd32 * 64'd65535 * 64'd255);
      sample(16'hFFFF);
    end
    idle(3);
    chk("t5_integral", longint'(integral), 64'd534765600);

    // Window 3 with idle gaps between samples
    cfg(6'd3, 8'd2);
    exp_q.push_back(64'd120);
    exp_q.push_back(64'd180);
    sample(16'd10); idle(2);
    sample(16'd20); idle(2);
    sample(16'd30); idle(2);
    sample(16'd40); idle(2);
    chk("t6_integral", longint'(integral), 64'd180);
    chk("t6_fill", longint'(fill_count), 64'd3);

    // Reset with a result in flight: nothing may emerge
    sample(16'd50);
    sample_valid = 1'b0;
    reset = 1'b1;
    cyc();
    chk("t6_rst_integral", longint'(integral), 64'd0);
    chk("t6_rst_out_valid", longint'(out_valid), 64'd0);
    chk("t6_rst_fill", longint'(fill_count), 64'd0);
    chk("t6_rst_win_full", longint'(win_full), 64'd0);
    reset = 1'b0;
    idle(3);

    // Interval 0 still pulses, with a zero integral
    cfg(6'd1, 8'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    sample(16'd77); sample(16'd3);
    idle(6);

    chk("queue_drained", longint'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
